// File: rtl/char_generator_pkg.sv
// Shared constants for the falling-character generator.
// Optional build macro: CHARGEN_DIGITS_EN (extends the alphabet with '0'..'9').
package char_gen_pkg;

    // LFSR geometry: x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam int unsigned LFSR_W    = 32;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Parameter defaults for the top level
    localparam logic [31:0] DEFAULT_SEED    = 32'hACE1_2D5B;
    localparam int unsigned DEFAULT_Y_LIMIT = 628;
    localparam int unsigned DEFAULT_Y_STEP  = 16;

    // ASCII bases for the two symbol groups
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;
    localparam logic [5:0] LETTER_COUNT  = 6'd26;

`ifdef CHARGEN_DIGITS_EN
    localparam logic [5:0] ALPHA_SIZE = 6'd36;
`else
    localparam logic [5:0] ALPHA_SIZE = 6'd26;
`endif

endpackage

// File: rtl/char_generator_lfsr32.sv
// 32-bit Galois LFSR with enable and asynchronous active-high reset.
// next_state is the value the register takes on the next enabled edge.
module lfsr32
    import char_gen_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] next_state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Shift right; fold the tap mask back in when a 1 falls out of bit 0
    always_comb begin
        next_state = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? LFSR_TAPS : '0);
        state_d    = en ? next_state : state_q;
    end

    // State register, seeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SEED;
        else     state_q <= state_d;
    end

endmodule

// File: rtl/char_generator.sv
// Falling-character descriptor source: maps each new LFSR value to an
// ASCII code, fall speed, initial vertical offset and a column that never
// repeats the previously issued one.
// Optional build macro: CHARGEN_DIGITS_EN (36-symbol alphabet a..z, 0..9).
module char_generator
    import char_gen_pkg::*;
#(
    parameter logic [31:0] SEED    = DEFAULT_SEED,
    parameter int unsigned Y_LIMIT = DEFAULT_Y_LIMIT,
    parameter int unsigned Y_STEP  = DEFAULT_Y_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] ch,
    output logic [2:0] speed,
    output logic [8:0] x,
    output logic [9:0] y,
    output logic       valid
);

    localparam logic [10:0] Y_LIM = 11'(Y_LIMIT);
    localparam logic [10:0] Y_STP = 11'(Y_STEP);

    logic [31:0] n;

    logic [7:0] ch_q, ch_d;
    logic [2:0] speed_q, speed_d;
    logic [8:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [9:0] prev_y_q, prev_y_d;
    logic       valid_q, valid_d;

    logic [5:0]  c;
    logic [7:0]  sym;
    logic [2:0]  s;
    logic [10:0] r;
    logic        unused_bits;

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .next_state (n)
    );

`ifdef CHARGEN_DIGITS_EN
    assign unused_bits = ^{n[31:28], n[7:6]};
`else
    assign unused_bits = ^{n[31:28], n[7:5]};
`endif

    // Descriptor mapping from the upcoming LFSR value; held when disabled
    always_comb begin
`ifdef CHARGEN_DIGITS_EN
        c = n[5:0];
`else
        c = {1'b0, n[4:0]};
`endif
        if (c >= ALPHA_SIZE) c = c - ALPHA_SIZE;
        sym = (c < LETTER_COUNT) ? ASCII_LOWER_A + 8'(c)
                                 : ASCII_DIGIT_0 + 8'(c - LETTER_COUNT);

        s = n[10:8];
        if (s == 3'd0) s = 3'd1;

        // Single fold into range, then step away from the last column
        r = {1'b0, n[27:18]};
        if (r >= Y_LIM) r = r - Y_LIM;
        if (r[9:0] == prev_y_q) begin
            r = r + Y_STP;
            if (r >= Y_LIM) r = r - Y_LIM;
        end

        ch_d     = ch_q;
        speed_d  = speed_q;
        x_d      = x_q;
        y_d      = y_q;
        prev_y_d = prev_y_q;
        valid_d  = en;
        if (en) begin
            ch_d     = sym;
            speed_d  = s;
            x_d      = {2'b00, n[17:11]};
            y_d      = r[9:0];
            prev_y_d = r[9:0];
        end
    end

    // Output and history registers; previous-y resets to an unmatchable value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q     <= ASCII_LOWER_A;
            speed_q  <= 3'd1;
            x_q      <= '0;
            y_q      <= '0;
            prev_y_q <= '1;
            valid_q  <= 1'b0;
        end else begin
            ch_q     <= ch_d;
            speed_q  <= speed_d;
            x_q      <= x_d;
            y_q      <= y_d;
            prev_y_q <= prev_y_d;
            valid_q  <= valid_d;
        end
    end

    assign ch    = ch_q;
    assign speed = speed_q;
    assign x     = x_q;
    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_char_generator.sv
// Directed self-checking bench for char_generator with an independent
// reference model of the LFSR and descriptor mapping.
module tb_char_generator;

    localparam logic [31:0] T_SEED = 32'hACE1_2D5B;
    localparam int          T_YLIM = 628;
    localparam int          T_YSTP = 16;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;
    logic [7:0] ch;
    logic [2:0] speed;
    logic [8:0] x;
    logic [9:0] y;
    logic       valid;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_lfsr;
    int          m_prev;
    int          e_ch, e_speed, e_x, e_y;
    int          repeats = 0;
    int          pulses;

    char_generator #(
        .SEED    (T_SEED),
        .Y_LIMIT (T_YLIM),
        .Y_STEP  (T_YSTP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .ch    (ch),
        .speed (speed),
        .x     (x),
        .y     (y),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_next(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    function automatic int m_col(input logic [31:0] n, input int prev);
        int r;
        r = int'(n[27:18]);
        if (r >= T_YLIM) r = r - T_YLIM;
        if (r == prev) begin
            r = r + T_YSTP;
            if (r >= T_YLIM) r = r - T_YLIM;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr  = T_SEED;
        m_prev  = 1023;
        e_ch    = 8'h61;
        e_speed = 1;
        e_x     = 0;
        e_y     = 0;
    endtask

    task automatic model_step();
        logic [31:0] n;
        int c, raw;
        n = m_next(m_lfsr);
        m_lfsr = n;
`ifdef CHARGEN_DIGITS_EN
        c = int'(n[5:0]);
        if (c >= 36) c = c - 36;
        e_ch = (c < 26) ? 8'h61 + c : 8'h30 + (c - 26);
`else
        c = int'(n[4:0]);
        if (c >= 26) c = c - 26;
        e_ch = 8'h61 + c;
`endif
        e_speed = int'(n[10:8]);
        if (e_speed == 0) e_speed = 1;
        e_x = int'(n[17:11]);
        raw = int'(n[27:18]);
        if (raw >= T_YLIM) raw = raw - T_YLIM;
        if (raw == m_prev) repeats++;
        e_y = m_col(n, m_prev);
        m_prev = e_y;
    endtask

    task automatic check_outputs(input string tag, input int exp_valid);
        check({tag, ".ch"},    int'(ch),    e_ch);
        check({tag, ".speed"}, int'(speed), e_speed);
        check({tag, ".x"},     int'(x),     e_x);
        check({tag, ".y"},     int'(y),     e_y);
        check({tag, ".valid"}, int'(valid), exp_valid);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One enabled edge followed by a check on the following low phase
    task automatic run_enabled(input string tag);
        int prev;
        en = 1'b1;
        prev = m_prev;
        @(negedge clk);
        model_step();
        check_outputs(tag, 1);
        check({tag, ".ch_range"}, int'((ch >= 8'h61 && ch <= 8'h7A)
`ifdef CHARGEN_DIGITS_EN
                                       || (ch >= 8'h30 && ch <= 8'h39)
`endif
                                       ), 1);
        check({tag, ".speed_range"}, int'(speed >= 3'd1), 1);
        check({tag, ".x_range"}, int'(x <= 9'd127), 1);
        check({tag, ".y_range"}, int'(y <= 10'd627), 1);
        check({tag, ".y_norepeat"}, int'(int'(y) != prev), 1);
    endtask

    initial begin
        clk_run = 1'b0;
        rst     = 1'b1;
        en      = 1'b0;
        model_reset();

        // Reset with the clock stopped
        #3;
        check_outputs("reset_noclk", 0);

        // Released, enable low: everything holds
        rst = 1'b0;
        #2;
        clk_run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_outputs("hold_en0", 0);
        end

        // First step from the seed, valid for exactly one cycle
        run_enabled("first_step");
        en = 1'b0;
        @(negedge clk);
        check_outputs("first_step_after", 0);

        // Reference model repeat-avoidance arithmetic on hand values
        check("model_y_wrap", m_col(32'(620) << 18, 620), 8);
        check("model_y_step", m_col(32'(100) << 18, 100), 116);

        // Enable gating 1,0,0,1 -> steps 1 and 2 of the free-running sequence
        do_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            en = (i == 0 || i == 3);
            @(negedge clk);
            if (en) model_step();
            pulses += int'(valid);
            check_outputs($sformatf("gate%0d", i), int'(en));
        end
        check("gate_pulses", pulses, 2);
        check("gate_lfsr_step2", int'(m_lfsr == m_next(m_next(T_SEED))), 1);

        // Run to cycle 500, then reset asynchronously mid-cycle
        do_reset();
        for (int i = 0; i < 500; i++) run_enabled("run500");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("midrun_reset", 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        check_outputs("midrun_hold", 0);
        run_enabled("restart_step1");
        check("restart_is_step1", int'(m_lfsr == m_next(T_SEED)), 1);

        // Long free-running sweep against the model
        for (int i = 0; i < 30000; i++) run_enabled("sweep");
        en = 1'b0;
        @(negedge clk);
        check_outputs("sweep_end", 0);
        $display("Info: repeat-avoidance events seen in model: %0d", repeats);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
